// File: rtl/vep_pkg.sv
// -----------------------------------------------------------------------------
// vep_pkg
// Shared definitions for the SOM image compressor VEP array sequencer and the
// blocks that sit around it (decompressor path reuses the delay line).
//   vep_state_e : sequencer states
//   NUM_VEP     : number of vector-element processors in the array (8x8)
//   TAG_W       : width of a VEP index / winner tag, packed as {y,x}
//   VEP_GRID    : side length of the square VEP grid
// -----------------------------------------------------------------------------
package vep_pkg;

    localparam int NUM_VEP  = 64;
    localparam int TAG_W    = 6;
    localparam int VEP_GRID = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        LOAD_LAST = 3'd2,
        ENCODE    = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } vep_state_e;

    // Index of the last VEP, in tag format.
    function automatic logic [TAG_W-1:0] last_vep_idx();
        return TAG_W'(NUM_VEP - 1);
    endfunction

endpackage : vep_pkg

// File: rtl/tag_delay_line.sv
// -----------------------------------------------------------------------------
// tag_delay_line
// DEPTH-stage valid + address shift register. An address presented with
// valid_i in cycle t appears on addr_o with valid_o in cycle t+DEPTH, lining it
// up with a result that takes DEPTH cycles to come back from the datapath.
// Asynchronous active-high reset flushes every stage.
//
// Parameters:
//   DEPTH : number of stages (>= 2)
//   AW    : address width
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   valid_i    in   address issued this cycle
//   addr_i     in   issued address
//   valid_o    out  delayed valid (last stage)
//   addr_o     out  delayed address (last stage)
//   inflight_o out  some entry is still in a stage before the last one, i.e.
//                   at least one more valid_o is still to come after this cycle
// -----------------------------------------------------------------------------
module tag_delay_line #(
    parameter int DEPTH = 3,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic          inflight_o
);

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0][AW-1:0] addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], valid_i};
            addr_q  <= {addr_q[DEPTH-2:0], addr_i};
        end
    end

    assign valid_o    = valid_q[DEPTH-1];
    assign addr_o     = addr_q[DEPTH-1];
    assign inflight_o = |valid_q[DEPTH-2:0];

endmodule : tag_delay_line

// File: rtl/vep_array_ctrl.sv
// -----------------------------------------------------------------------------
// vep_array_ctrl
// Sequencer for the 8x8 VEP array. On start it loads the 64 codebook entries
// from RAM_W into the VEPs (one per cycle), then streams NUM_PIX pixels from
// RAM_IF into all VEPs in parallel (one per cycle) and writes the winner tag
// returned by the external min-distance tree into RAM_T at the pixel address.
//
// Optional build macro: VEP_ARRAY_CTRL_PERF_EN adds frame_cycles (cycles from
// start acceptance through the done cycle) and tag_hist_hit (winner tag of the
// final pixel).
//
// Parameters:
//   PIX_AW   : RAM_IF / RAM_T address width
//   NUM_PIX  : pixels per frame, 1..2^PIX_AW
//   PIPE_LAT : cycles from ram_if_rd to winner_tag valid (>= 2)
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start                         frame start pulse, only honoured in IDLE
//   busy, done                    status; done pulses once per frame
//   ram_w_rd, ram_w_addr          codebook read
//   weight_update, vep_sel,       codebook write into the addressed VEP
//   pixel_en
//   ram_if_rd, ram_if_addr        pixel read
//   winner_tag                    {y,x} of the min-distance VEP
//   ram_t_we, ram_t_addr, ram_t_d tag write
//   frame_cycles, tag_hist_hit    (VEP_ARRAY_CTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module vep_array_ctrl
    import vep_pkg::*;
#(
    parameter int PIX_AW   = 14,
    parameter int NUM_PIX  = 16384,
    parameter int PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_w_rd,
    output logic [TAG_W-1:0]  ram_w_addr,
    output logic              weight_update,
    output logic [TAG_W-1:0]  vep_sel,
    output logic              pixel_en,
    output logic              ram_if_rd,
    output logic [PIX_AW-1:0] ram_if_addr,
    input  logic [TAG_W-1:0]  winner_tag,
    output logic              ram_t_we,
    output logic [PIX_AW-1:0] ram_t_addr,
    output logic [TAG_W-1:0]  ram_t_d
`ifdef VEP_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]       frame_cycles,
    output logic [TAG_W-1:0]  tag_hist_hit
`endif
);

    localparam logic [TAG_W-1:0]  LAST_VEP = last_vep_idx();
    localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(NUM_PIX - 1);

    vep_state_e        state_q;
    logic [TAG_W-1:0]  w_cnt_q;
    logic [PIX_AW-1:0] p_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              ram_w_rd_q;
    logic              weight_update_q;
    logic              pixel_en_q;
    logic [TAG_W-1:0]  vep_sel_q;
    logic              ram_if_rd_q;

    logic              dl_valid;
    logic [PIX_AW-1:0] dl_addr;
    logic              dl_inflight;

    // ------------------------------------------------------------------
    // Sequencer. All outputs are registered alongside the state, so an
    // output is high in exactly the cycles the FSM spends in the owning
    // state. The counters double as the RAM addresses and are parked at 0
    // outside their phase.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            w_cnt_q         <= '0;
            p_cnt_q         <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            ram_w_rd_q      <= 1'b0;
            weight_update_q <= 1'b0;
            pixel_en_q      <= 1'b0;
            vep_sel_q       <= '0;
            ram_if_rd_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        busy_q     <= 1'b1;
                        ram_w_rd_q <= 1'b1;
                        w_cnt_q    <= '0;
                    end
                end

                LOAD: begin
                    // RAM_W data for the index read this cycle arrives next
                    // cycle, so the VEP write trails the read by one.
                    weight_update_q <= 1'b1;
                    pixel_en_q      <= 1'b1;
                    vep_sel_q       <= w_cnt_q;
                    if (w_cnt_q == LAST_VEP) begin
                        state_q    <= LOAD_LAST;
                        ram_w_rd_q <= 1'b0;
                        w_cnt_q    <= '0;
                    end else begin
                        w_cnt_q <= w_cnt_q + TAG_W'(1);
                    end
                end

                LOAD_LAST: begin
                    // VEP 63 is written this cycle; weights freeze from here.
                    weight_update_q <= 1'b0;
                    pixel_en_q      <= 1'b0;
                    vep_sel_q       <= '0;
                    state_q         <= ENCODE;
                    ram_if_rd_q     <= 1'b1;
                    p_cnt_q         <= '0;
                end

                ENCODE: begin
                    // Terminal compare instead of wrap so NUM_PIX = 2^PIX_AW
                    // works without an extra counter bit.
                    if (p_cnt_q == LAST_PIX) begin
                        state_q     <= DRAIN;
                        ram_if_rd_q <= 1'b0;
                        p_cnt_q     <= '0;
                    end else begin
                        p_cnt_q <= p_cnt_q + PIX_AW'(1);
                    end
                end

                DRAIN: begin
                    // Leave once the only entry left (if any) is the one
                    // being written to RAM_T this cycle.
                    if (!dl_inflight) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Address alignment for the tag write: each pixel address follows the
    // datapath latency so it meets its own winner tag.
    // ------------------------------------------------------------------
    tag_delay_line #(
        .DEPTH (PIPE_LAT),
        .AW    (PIX_AW)
    ) u_tag_delay_line (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (ram_if_rd_q),
        .addr_i     (p_cnt_q),
        .valid_o    (dl_valid),
        .addr_o     (dl_addr),
        .inflight_o (dl_inflight)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign ram_w_rd      = ram_w_rd_q;
    assign ram_w_addr    = w_cnt_q;
    assign weight_update = weight_update_q;
    assign vep_sel       = vep_sel_q;
    assign pixel_en      = pixel_en_q;
    assign ram_if_rd     = ram_if_rd_q;
    assign ram_if_addr   = p_cnt_q;

    // winner_tag is only meaningful in the cycle it is valid, so the write
    // is combinational from the last delay stage.
    assign ram_t_we      = dl_valid;
    assign ram_t_addr    = dl_valid ? dl_addr : '0;
    assign ram_t_d       = dl_valid ? winner_tag : '0;

`ifdef VEP_ARRAY_CTRL_PERF_EN
    logic [31:0]      frame_cycles_q;
    logic [TAG_W-1:0] tag_hist_hit_q;

    // The start-acceptance cycle counts as 1; every non-IDLE cycle (through
    // DONE) adds one, so the value settles right after done and holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cycles_q <= '0;
            tag_hist_hit_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (start) begin
                    frame_cycles_q <= 32'd1;
                end
            end else begin
                frame_cycles_q <= frame_cycles_q + 32'd1;
            end
            if (dl_valid && (dl_addr == LAST_PIX)) begin
                tag_hist_hit_q <= winner_tag;
            end
        end
    end

    assign frame_cycles = frame_cycles_q;
    assign tag_hist_hit = tag_hist_hit_q;
`endif

endmodule : vep_array_ctrl

// File: tb/tb_vep_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vep_array_ctrl
// Instance A: NUM_PIX=4, PIPE_LAT=3. Instance B: NUM_PIX=1, PIPE_LAT=3.
// A stub min-distance tree returns ram_if_addr[5:0] ^ 6'h2A, PIPE_LAT cycles
// after the read. Expected reads/writes are queued when start is driven and
// popped as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_vep_array_ctrl;

    localparam int AW  = 14;
    localparam int PL  = 3;
    localparam int NPA = 4;
    localparam int NPB = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A signals ----------------
    logic          a_start, a_busy, a_done, a_ram_w_rd, a_weight_update, a_pixel_en;
    logic          a_ram_if_rd, a_ram_t_we;
    logic [5:0]    a_ram_w_addr, a_vep_sel, a_winner_tag, a_ram_t_d;
    logic [AW-1:0] a_ram_if_addr, a_ram_t_addr;
    // ---------------- instance B signals ----------------
    logic          b_start, b_busy, b_done, b_ram_w_rd, b_weight_update, b_pixel_en;
    logic          b_ram_if_rd, b_ram_t_we;
    logic [5:0]    b_ram_w_addr, b_vep_sel, b_winner_tag, b_ram_t_d;
    logic [AW-1:0] b_ram_if_addr, b_ram_t_addr;
`ifdef VEP_ARRAY_CTRL_PERF_EN
    logic [31:0]   a_frame_cycles, b_frame_cycles;
    logic [5:0]    a_tag_hist, b_tag_hist;
`endif

    vep_array_ctrl #(.PIX_AW(AW), .NUM_PIX(NPA), .PIPE_LAT(PL)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .ram_w_rd(a_ram_w_rd), .ram_w_addr(a_ram_w_addr),
        .weight_update(a_weight_update), .vep_sel(a_vep_sel), .pixel_en(a_pixel_en),
        .ram_if_rd(a_ram_if_rd), .ram_if_addr(a_ram_if_addr), .winner_tag(a_winner_tag),
        .ram_t_we(a_ram_t_we), .ram_t_addr(a_ram_t_addr), .ram_t_d(a_ram_t_d)
`ifdef VEP_ARRAY_CTRL_PERF_EN
        , .frame_cycles(a_frame_cycles), .tag_hist_hit(a_tag_hist)
`endif
    );

    vep_array_ctrl #(.PIX_AW(AW), .NUM_PIX(NPB), .PIPE_LAT(PL)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .ram_w_rd(b_ram_w_rd), .ram_w_addr(b_ram_w_addr),
        .weight_update(b_weight_update), .vep_sel(b_vep_sel), .pixel_en(b_pixel_en),
        .ram_if_rd(b_ram_if_rd), .ram_if_addr(b_ram_if_addr), .winner_tag(b_winner_tag),
        .ram_t_we(b_ram_t_we), .ram_t_addr(b_ram_t_addr), .ram_t_d(b_ram_t_d)
`ifdef VEP_ARRAY_CTRL_PERF_EN
        , .frame_cycles(b_frame_cycles), .tag_hist_hit(b_tag_hist)
`endif
    );

    // ---------------- stub min-distance trees ----------------
    logic [5:0] a_stub [PL];
    logic [5:0] b_stub [PL];
    always @(posedge clk) begin
        a_stub[0] <= a_ram_if_rd ? (a_ram_if_addr[5:0] ^ 6'h2A) : 6'h00;
        b_stub[0] <= b_ram_if_rd ? (b_ram_if_addr[5:0] ^ 6'h2A) : 6'h00;
        for (int i = 1; i < PL; i++) begin
            a_stub[i] <= a_stub[i-1];
            b_stub[i] <= b_stub[i-1];
        end
    end
    assign a_winner_tag = a_stub[PL-1];
    assign b_winner_tag = b_stub[PL-1];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    typedef struct { int addr; int tag; } tw_t;
    int  exp_w[$];
    int  exp_sel[$];
    int  exp_if[$];
    tw_t exp_t[$];
    tw_t a_e;

    logic mon_en = 1'b0;
    int   a_start_cyc = 0, b_start_cyc = 0;
    int   a_done_cnt = 0, a_wu_cnt = 0, a_tw_cnt = 0;
    int   b_rd_cnt = 0, b_we_cnt = 0, b_done_cnt = 0;

    // Scoreboard monitor for A, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_ram_w_rd) begin
                chk("rd_exclusive", 32'(a_ram_if_rd), 32'd0);
                if (exp_w.size() == 0) chk("w_rd_unexpected", 32'd1, 32'd0);
                else chk("ram_w_addr", 32'(a_ram_w_addr), 32'(exp_w.pop_front()));
            end
            if (a_weight_update) begin
                a_wu_cnt++;
                chk("pixel_en", 32'(a_pixel_en), 32'd1);
                if (exp_sel.size() == 0) chk("wu_unexpected", 32'd1, 32'd0);
                else chk("vep_sel", 32'(a_vep_sel), 32'(exp_sel.pop_front()));
            end
            if (a_ram_if_rd) begin
                chk("wu_frozen", 32'(a_weight_update), 32'd0);
                if (exp_if.size() == 0) chk("if_rd_unexpected", 32'd1, 32'd0);
                else chk("ram_if_addr", 32'(a_ram_if_addr), 32'(exp_if.pop_front()));
            end
            if (a_ram_t_we) begin
                a_tw_cnt++;
                chk("wu_in_drain", 32'(a_weight_update), 32'd0);
                if (exp_t.size() == 0) chk("t_we_unexpected", 32'd1, 32'd0);
                else begin
                    a_e = exp_t.pop_front();
                    chk("ram_t_addr", 32'(a_ram_t_addr), 32'(a_e.addr));
                    chk("ram_t_d", 32'(a_ram_t_d), 32'(a_e.tag));
                    $display("A tag write cyc=%0d addr=%0d data=0x%0h", cyc, a_ram_t_addr, a_ram_t_d);
                end
            end
            if (a_done) begin
                a_done_cnt++;
                chk("a_done_latency", 32'(cyc - a_start_cyc), 32'd73);
            end
        end
        if (b_ram_if_rd) begin
            b_rd_cnt++;
            chk("b_if_addr", 32'(b_ram_if_addr), 32'd0);
        end
        if (b_ram_t_we) begin
            b_we_cnt++;
            chk("b_t_addr", 32'(b_ram_t_addr), 32'd0);
            chk("b_t_d", 32'(b_ram_t_d), 32'h2A);
            $display("B tag write cyc=%0d addr=%0d data=0x%0h", cyc, b_ram_t_addr, b_ram_t_d);
        end
        if (b_done) begin
            b_done_cnt++;
            chk("b_done_latency", 32'(cyc - b_start_cyc), 32'd70);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_outputs", 32'(|{a_busy, a_done, a_ram_w_rd, a_ram_w_addr, a_weight_update,
            a_vep_sel, a_pixel_en, a_ram_if_rd, a_ram_if_addr, a_ram_t_we, a_ram_t_addr, a_ram_t_d}), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of LOAD.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (a_ram_w_rd && a_ram_w_addr == 6'd20) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_w_cnt20", 32'(found), 32'd1);
        $display("reset asserted mid-LOAD cyc=%0d", cyc);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", 32'(|{a_busy, a_done, a_ram_w_rd, a_ram_w_addr, a_weight_update,
            a_vep_sel, a_pixel_en, a_ram_if_rd, a_ram_if_addr, a_ram_t_we, a_ram_t_addr, a_ram_t_d}), 32'd0);
        chk("rst_mid_busy", 32'(a_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(a_ram_w_rd), 32'd0);

        // Full frame on A, expected traffic queued with the start.
        for (int i = 0; i < 64; i++) begin
            exp_w.push_back(i);
            exp_sel.push_back(i);
        end
        for (int p = 0; p < NPA; p++) begin
            exp_if.push_back(p);
            exp_t.push_back('{p, (p % 64) ^ 'h2A});
        end
        mon_en = 1'b1;
        a_start_cyc = cyc;
        a_start = 1'b1;
        $display("A start cyc=%0d", cyc);
        @(negedge clk);
        a_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (a_ram_if_rd) found = 1'b1;
            else @(negedge clk);
        end
        chk("a_encode_seen", 32'(found), 32'd1);
        a_start = 1'b1;                     // ignored: ENCODE
        @(negedge clk);
        a_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (a_done) found = 1'b1;
            else @(negedge clk);
        end
        chk("a_done_seen", 32'(found), 32'd1);
        a_start = 1'b1;                     // ignored: coincident with done
        @(negedge clk);
        a_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("a_busy_after_done", 32'(a_busy), 32'd0);
        chk("a_done_count", 32'(a_done_cnt), 32'd1);
        chk("a_wu_count", 32'(a_wu_cnt), 32'd64);
        chk("a_tw_count", 32'(a_tw_cnt), 32'(NPA));
        chk("a_queues_left", 32'(exp_w.size() + exp_sel.size() + exp_if.size() + exp_t.size()), 32'd0);
`ifdef VEP_ARRAY_CTRL_PERF_EN
        chk("a_frame_cycles", a_frame_cycles, 32'd74);
        chk("a_tag_hist_hit", 32'(a_tag_hist), 32'h29);
`endif

        // Single-pixel frame on B.
        b_start_cyc = cyc;
        b_start = 1'b1;
        $display("B start cyc=%0d", cyc);
        @(negedge clk);
        b_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (b_done) found = 1'b1;
            else @(negedge clk);
        end
        chk("b_done_seen", 32'(found), 32'd1);
        repeat (10) @(negedge clk);
        chk("b_rd_count", 32'(b_rd_cnt), 32'd1);
        chk("b_we_count", 32'(b_we_cnt), 32'd1);
        chk("b_done_count", 32'(b_done_cnt), 32'd1);
        chk("b_busy_after_done", 32'(b_busy), 32'd0);
`ifdef VEP_ARRAY_CTRL_PERF_EN
        chk("b_frame_cycles", b_frame_cycles, 32'd71);
        chk("b_tag_hist_hit", 32'(b_tag_hist), 32'h2A);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_vep_array_ctrl

// File: doc/vep_array_ctrl.md
Name: vep_array_ctrl

Overview:
- Sequencer for the 8x8 VEP array in the SOM image compressor.
- Phase 1: loads 64 codebook entries from RAM_W into the VEPs, one per cycle.
- Phase 2: streams image pixels from RAM_IF into all VEPs in parallel, one per cycle.
- Captures the winner tag produced by the external min-distance tree and writes it to RAM_T at the pixel's address.

Parameters:
- PIX_AW, 14: RAM_IF / RAM_T address width.
- NUM_PIX, 16384: pixels per frame, 1..2^PIX_AW.
- PIPE_LAT, 3: cycles from ram_if_rd issue to winner_tag valid; 2 RAM/VEP cycles plus min-tree stages; minimum 2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle pulse that begins a frame; sampled only in IDLE.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse after the last tag write.
- ram_w_rd, output, 1: RAM_W read strobe.
- ram_w_addr, output, 6: codebook index {y,x}.
- weight_update, output, 1: write enable to the addressed VEP.
- vep_sel, output, 6: VEP index {y,x}, decoded one-hot outside this block.
- pixel_en, output, 1: high only while weight_update is valid.
- ram_if_rd, output, 1: RAM_IF read strobe.
- ram_if_addr, output, PIX_AW: pixel address.
- winner_tag, input, 6: {y,x} of the minimum-distance VEP; valid PIPE_LAT cycles after ram_if_rd.
- ram_t_we, output, 1: RAM_T write enable.
- ram_t_addr, output, PIX_AW: tag address.
- ram_t_d, output, 6: tag data.

Behaviour:
- Reset (async): state IDLE; all counters 0; every output 0.
- RAM reads have 1-cycle latency. Data read at cycle t is valid at cycle t+1.
- IDLE:
  - start=1 -> LOAD, w_cnt=0.
  - start is ignored in every other state.
- LOAD:
  - Each cycle: ram_w_rd=1, ram_w_addr=w_cnt, w_cnt++.
  - Registered one cycle later: weight_update=1, pixel_en=1, vep_sel=previous w_cnt.
  - w_cnt==63 issued -> LOAD_LAST.
- LOAD_LAST: one cycle that finishes VEP 63's write (weight_update=1, vep_sel=63); next -> ENCODE, p_cnt=0.
- ENCODE:
  - Each cycle: ram_if_rd=1, ram_if_addr=p_cnt, p_cnt++.
  - Each issued address enters a PIPE_LAT-deep valid/address shift register.
  - After p_cnt==NUM_PIX-1 is issued -> DRAIN.
- DRAIN: no reads; wait until the shift register is empty -> DONE.
- Tag write: in any state, when the shift-register output is valid, drive ram_t_we=1, ram_t_addr=delayed address, ram_t_d=winner_tag, all in the same cycle.
- DONE: done=1 for one cycle -> IDLE.
- Output constraints:
  - weight_update and pixel_en are never high during ENCODE or DRAIN, so VEP weights are frozen.
  - ram_w_rd and ram_if_rd are never high in the same cycle.
- Throughput: exactly 1 pixel/cycle, no bubbles. Frame latency = 1 + 64 + 1 + NUM_PIX + PIPE_LAT + 1 cycles from start to done.
- Boundaries:
  - NUM_PIX=1: ENCODE lasts one cycle.
  - p_cnt never wraps; the terminal compare uses NUM_PIX-1.
  - start coincident with done: start is ignored.
  - rst mid-frame: returns to IDLE immediately; the pipe is flushed; no further RAM_T writes.

Optional Feature:
- Macro: VEP_ARRAY_CTRL_PERF_EN.
- Defined:
  - Adds output frame_cycles [31:0], counting cycles from start acceptance through the done cycle inclusive.
  - Holds its value until the next start; cleared on reset.
  - Adds output tag_hist_hit [5:0]: the winner tag of the final pixel.
- Undefined: the ports are absent; no counter logic.

Decomposition:
- Shared package vep_pkg:
  - state enum (IDLE, LOAD, LOAD_LAST, ENCODE, DRAIN, DONE);
  - NUM_VEP=64;
  - TAG_W=6;
  - VEP_GRID=8.
- Sub-module tag_delay_line: parameterised PIPE_LAT-deep valid+address shift register with async reset. It is reused by the decompressor path.

Test Plan:
- Reset mid-LOAD at w_cnt=20 -> all outputs 0 next cycle; busy=0; a later start reloads from ram_w_addr=0.
- start with NUM_PIX=4, PIPE_LAT=3 -> weight_update pulses 64 times with vep_sel 0..63 consecutive; ram_if_addr 0,1,2,3; ram_t_we at ram_t_addr 0..3; done exactly 73 cycles after start.
- Stub tree returns winner_tag = ram_if_addr[5:0] ^ 6'h2A -> RAM_T contents match that function for every address.
- start asserted during ENCODE and coincident with done -> ignored; no second frame; busy drops after done.
- NUM_PIX=1 -> single ram_if_rd; single ram_t_we at address 0; done 70 cycles after start.
- VEP_ARRAY_CTRL_PERF_EN defined, NUM_PIX=4 -> frame_cycles=74 after done.
